// File: rtl/ioport_pkg.sv
// Shared definitions for the I/O port decoder: FSM states, default widths
// and the channel-slot numbering used by the SBC top level.
package ioport_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } ioport_state_t;

  localparam int ADDR_W_DEF = 8;
  localparam int WS_W_DEF   = 3;

  // Channel slots as wired by the SBC top level
  localparam int CON    = 0;
  localparam int FBAR   = 1;
  localparam int MISC   = 2;
  localparam int IOBYTE = 3;
  localparam int RAMA16 = 4;
  localparam int PORTFF = 5;

endpackage

// File: rtl/ioport_match.sv
// Combinational base/mask window compare across all channels; reports the
// lowest-index channel that matches the address and access direction.
module ioport_match
  import ioport_pkg::*;
#(
  parameter int NUM_CH = 8,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int IDX_W  = 3
) (
  input  logic [ADDR_W-1:0]        address,
  input  logic                     is_read,
  input  logic [NUM_CH*ADDR_W-1:0] ch_base,
  input  logic [NUM_CH*ADDR_W-1:0] ch_mask,
  input  logic [NUM_CH-1:0]        ch_rd_en,
  input  logic [NUM_CH-1:0]        ch_wr_en,
  output logic                     hit,
  output logic [IDX_W-1:0]         hit_idx
);

  logic [NUM_CH-1:0] match;

  always_comb begin
    match = '0;
    for (int unsigned n = 0; n < NUM_CH; n++) begin
      match[n] = (((address ^ ch_base[n*ADDR_W +: ADDR_W]) & ch_mask[n*ADDR_W +: ADDR_W]) == '0)
                 && (is_read ? ch_rd_en[n] : ch_wr_en[n]);
    end
  end

  // Scan downwards so the lowest matching index is the last one written
  always_comb begin
    hit     = |match;
    hit_idx = '0;
    for (int unsigned n = NUM_CH; n > 0; n--) begin
      if (match[n-1]) hit_idx = IDX_W'(n - 1);
    end
  end

endmodule

// File: rtl/io_port_decoder_ws.sv
// Registered I/O port decoder with per-channel wait states and ready control.
// Optional sticky miss reporting is built when IOPORT_DECODE_ERR_EN is defined.
module io_port_decoder_ws
  import ioport_pkg::*;
#(
  parameter int NUM_CH = 8,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int WS_W   = WS_W_DEF,
  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [ADDR_W-1:0]        address,
  input  logic                     ioread,
  input  logic                     iowrite,
  input  logic [NUM_CH*ADDR_W-1:0] ch_base,
  input  logic [NUM_CH*ADDR_W-1:0] ch_mask,
  input  logic [NUM_CH-1:0]        ch_rd_en,
  input  logic [NUM_CH-1:0]        ch_wr_en,
  input  logic [NUM_CH*WS_W-1:0]   ch_wait,
  output logic [NUM_CH-1:0]        cs,
  output logic                     rd_stb,
  output logic                     wr_stb,
  output logic [IDX_W-1:0]         hit_idx,
  output logic                     ready
`ifdef IOPORT_DECODE_ERR_EN
  ,
  input  logic                     err_clr,
  output logic                     miss_err,
  output logic [ADDR_W-1:0]        miss_addr,
  output logic                     miss_wr
`endif
);

  ioport_state_t state_q, state_d;

  logic              req, req_q, start;
  logic              hit;
  logic [IDX_W-1:0]  match_idx;
  logic [WS_W-1:0]   sel_wait;
  logic [WS_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              dir_rd_q, dir_rd_d;
  logic [NUM_CH-1:0] cs_d;
  logic              ready_d, rd_stb_d, wr_stb_d;

  assign req      = ioread ^ iowrite;
  assign start    = req && !req_q && (state_q == IDLE);
  assign sel_wait = ch_wait[match_idx*WS_W +: WS_W];

  ioport_match #(
    .NUM_CH (NUM_CH),
    .ADDR_W (ADDR_W),
    .IDX_W  (IDX_W)
  ) u_match (
    .address  (address),
    .is_read  (ioread),
    .ch_base  (ch_base),
    .ch_mask  (ch_mask),
    .ch_rd_en (ch_rd_en),
    .ch_wr_en (ch_wr_en),
    .hit      (hit),
    .hit_idx  (match_idx)
  );

  // Left unreset so a request level held across reset cannot fake an edge
  always_ff @(posedge clock) begin
    req_q <= req;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      dir_rd_q <= 1'b0;
      cs       <= '0;
      ready    <= 1'b1;
      rd_stb   <= 1'b0;
      wr_stb   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      dir_rd_q <= dir_rd_d;
      cs       <= cs_d;
      ready    <= ready_d;
      rd_stb   <= rd_stb_d;
      wr_stb   <= wr_stb_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (start && hit) state_d = (sel_wait != '0) ? WAIT : STROBE;
      WAIT: begin
        if (!req)                     state_d = IDLE;
        else if (cnt_q == WS_W'(1))   state_d = STROBE;
      end
      STROBE: state_d = HOLD;
      HOLD:   if (!req) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs and access context
  always_comb begin
    cs_d     = cs;
    ready_d  = ready;
    rd_stb_d = 1'b0;
    wr_stb_d = 1'b0;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    dir_rd_d = dir_rd_q;
    unique case (state_q)
      IDLE: begin
        cs_d    = '0;
        ready_d = 1'b1;
        if (start && hit) begin
          idx_d    = match_idx;
          dir_rd_d = ioread;
          cs_d     = NUM_CH'(1) << match_idx;
          ready_d  = 1'b0;
          cnt_d    = sel_wait;
        end
      end
      WAIT: begin
        if (!req) begin
          cs_d    = '0;
          ready_d = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q - WS_W'(1);
        end
      end
      STROBE: begin
        rd_stb_d = dir_rd_q;
        wr_stb_d = !dir_rd_q;
        ready_d  = 1'b1;
      end
      HOLD: begin
        ready_d = 1'b1;
        if (!req) cs_d = '0;
      end
      default: begin
        cs_d    = '0;
        ready_d = 1'b1;
      end
    endcase
  end

  assign hit_idx = idx_q;

`ifdef IOPORT_DECODE_ERR_EN
  logic miss;
  assign miss = start && !hit;

  // A miss coinciding with a clear both keeps the flag set and records this miss
  always_ff @(posedge clock) begin
    if (reset) begin
      miss_err  <= 1'b0;
      miss_addr <= '0;
      miss_wr   <= 1'b0;
    end else if (miss) begin
      miss_err <= 1'b1;
      if (!miss_err || err_clr) begin
        miss_addr <= address;
        miss_wr   <= !ioread;
      end
    end else if (err_clr) begin
      miss_err <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_io_port_decoder_ws.sv
// Scoreboard bench for io_port_decoder_ws: directed scenarios followed by
// randomized accesses checked against a rule-level decode model.
module tb_io_port_decoder_ws;
  import ioport_pkg::*;

  localparam int NUM_CH = 8;
  localparam int AW     = 8;
  localparam int WW     = 3;

  logic                 clock = 1'b0;
  logic                 reset = 1'b1;
  logic [AW-1:0]        address = '0;
  logic                 ioread = 1'b0;
  logic                 iowrite = 1'b0;
  logic [NUM_CH*AW-1:0] ch_base = '0;
  logic [NUM_CH*AW-1:0] ch_mask = '0;
  logic [NUM_CH-1:0]    ch_rd_en = '0;
  logic [NUM_CH-1:0]    ch_wr_en = '0;
  logic [NUM_CH*WW-1:0] ch_wait = '0;
  logic [NUM_CH-1:0]    cs;
  logic                 rd_stb, wr_stb;
  logic [2:0]           hit_idx;
  logic                 ready;
`ifdef IOPORT_DECODE_ERR_EN
  logic                 err_clr = 1'b0;
  logic                 miss_err, miss_wr;
  logic [AW-1:0]        miss_addr;
`endif

  io_port_decoder_ws #(.NUM_CH(NUM_CH), .ADDR_W(AW), .WS_W(WW)) dut (
    .clock(clock), .reset(reset), .address(address), .ioread(ioread), .iowrite(iowrite),
    .ch_base(ch_base), .ch_mask(ch_mask), .ch_rd_en(ch_rd_en), .ch_wr_en(ch_wr_en),
    .ch_wait(ch_wait), .cs(cs), .rd_stb(rd_stb), .wr_stb(wr_stb), .hit_idx(hit_idx),
    .ready(ready)
`ifdef IOPORT_DECODE_ERR_EN
    , .err_clr(err_clr), .miss_err(miss_err), .miss_addr(miss_addr), .miss_wr(miss_wr)
`endif
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference configuration and model state
  logic [7:0] c_base[NUM_CH];
  logic [7:0] c_mask[NUM_CH];
  bit         c_rd[NUM_CH];
  bit         c_wr[NUM_CH];
  int         c_wt[NUM_CH];
  bit         m_err = 0;
  logic [7:0] m_addr = '0;
  bit         m_wr = 0;

  typedef struct { bit rd; int idx; int w; } exp_t;
  exp_t sbq[$];
  int   n_pushed = 0;
  int   n_seen   = 0;

  function automatic logic [7:0] onehot(input int i);
    logic [7:0] one;
    one = 8'd1;
    return one << i;
  endfunction

  // First channel whose masked bits equal the address and that accepts the direction
  function automatic int model_hit(input logic [7:0] a, input bit rd);
    for (int c = 0; c < NUM_CH; c++) begin
      if ((a & c_mask[c]) == (c_base[c] & c_mask[c]) && (rd ? c_rd[c] : c_wr[c])) return c;
    end
    return -1;
  endfunction

  task automatic apply_cfg();
    for (int c = 0; c < NUM_CH; c++) begin
      ch_base[c*AW +: AW] = c_base[c];
      ch_mask[c*AW +: AW] = c_mask[c];
      ch_rd_en[c]         = c_rd[c];
      ch_wr_en[c]         = c_wr[c];
      ch_wait[c*WW +: WW] = 3'(c_wt[c]);
    end
  endtask

  task automatic set_ch(input int c, input logic [7:0] b, input logic [7:0] m,
                        input bit rd, input bit wr, input int w);
    c_base[c] = b; c_mask[c] = m; c_rd[c] = rd; c_wr[c] = wr; c_wt[c] = w;
  endtask

  task automatic check_miss();
`ifdef IOPORT_DECODE_ERR_EN
    check("miss_err", miss_err, m_err);
    if (m_err) begin
      check("miss_addr", miss_addr, m_addr);
      check("miss_wr", miss_wr, m_wr);
    end
`endif
  endtask

  // One access: request held for h sampled edges, then released for 3 cycles
  task automatic do_access(input bit rd, input logic [7:0] a, input int h,
                           input bit clr, input bit perturb);
    int idx, w;
    bit hit;
    idx = model_hit(a, rd);
    hit = (idx >= 0);
    w   = hit ? c_wt[idx] : 0;
    if (hit && h >= w + 1) begin
      sbq.push_back('{rd, idx, w});
      n_pushed++;
    end
    if (!hit) begin
      if (!m_err || clr) begin m_addr = a; m_wr = !rd; end
      m_err = 1;
    end else if (clr) begin
      m_err = 0;
    end
    @(negedge clock);
    address = a; ioread = rd; iowrite = !rd;
`ifdef IOPORT_DECODE_ERR_EN
    err_clr = clr;
`endif
    @(posedge clock);
    @(negedge clock);
`ifdef IOPORT_DECODE_ERR_EN
    err_clr = 1'b0;
`endif
    check("start_cs", cs, hit ? onehot(idx) : 8'h00);
    check("start_ready", ready, !hit);
    if (hit) check("start_idx", hit_idx, idx);
    if (perturb) address = 8'($urandom);
    if (h >= 2) begin
      repeat (h - 1) @(posedge clock);
      @(negedge clock);
      check("held_cs", cs, hit ? onehot(idx) : 8'h00);
      check("held_ready", ready, !(hit && (h - 1) <= w));
    end
    ioread = 1'b0; iowrite = 1'b0;
    repeat (3) @(negedge clock);
    check("idle_cs", cs, 0);
    check("idle_ready", ready, 1);
    check_miss();
  endtask

  // Monitor: every strobe must match the oldest expected access
  int low_run = 0;
  always @(negedge clock) begin
    exp_t e;
    if (rd_stb || wr_stb) begin
      if (sbq.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_strobe: rd_stb=%0b wr_stb=%0b, expected none (t=%0t)",
                 rd_stb, wr_stb, $time);
      end else begin
        e = sbq.pop_front();
        n_seen++;
        check("stb_rd", rd_stb, e.rd);
        check("stb_wr", wr_stb, !e.rd);
        check("stb_idx", hit_idx, e.idx);
        check("stb_cs", cs, onehot(e.idx));
        check("ready_low_cycles", low_run, e.w + 1);
      end
      low_run = 0;
    end else if (!ready) begin
      low_run++;
    end else begin
      low_run = 0;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached with %0d accesses outstanding", sbq.size());
    $fatal(1, "time limit");
  end

  initial begin
    for (int c = 0; c < NUM_CH; c++) set_ch(c, 8'h00, 8'hFF, 0, 0, 0);
    apply_cfg();
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    check("rst_cs", cs, 0);
    check("rst_ready", ready, 1);
    check("rst_rd_stb", rd_stb, 0);
    check("rst_wr_stb", wr_stb, 0);
    check("rst_hit_idx", hit_idx, 0);
    check_miss();

    // Read-only window and a wait-state channel
    set_ch(CON,  8'h00, 8'hFE, 1, 0, 0);
    set_ch(FBAR, 8'h06, 8'hFF, 1, 1, 2);
    apply_cfg();
    do_access(1, 8'h01, 3, 0, 0);
    do_access(0, 8'h01, 3, 0, 0);
    do_access(0, 8'h06, 5, 0, 0);

    // Both strobes requested at once: no access
    @(negedge clock);
    address = 8'h06; ioread = 1'b1; iowrite = 1'b1;
    repeat (4) begin
      @(negedge clock);
      check("both_cs", cs, 0);
      check("both_ready", ready, 1);
    end
    ioread = 1'b0; iowrite = 1'b0;
    repeat (2) @(negedge clock);

    // Abort while waiting
    do_access(0, 8'h06, 1, 0, 0);

    // Reset on the second wait cycle
    c_wt[FBAR] = 3;
    apply_cfg();
    @(negedge clock);
    address = 8'h06; iowrite = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1; iowrite = 1'b0;
    m_err = 0; m_addr = '0; m_wr = 0;
    @(negedge clock);
    reset = 1'b0;
    check("rst_wait_cs", cs, 0);
    check("rst_wait_ready", ready, 1);
    check("rst_wait_idx", hit_idx, 0);
    repeat (6) @(negedge clock);
    do_access(0, 8'h06, 6, 0, 0);

    // Exact-match channel ahead of a catch-all
    set_ch(IOBYTE, 8'h36, 8'hFF, 1, 1, 1);
    set_ch(7,      8'h00, 8'h00, 1, 1, 0);
    apply_cfg();
    do_access(1, 8'h36, 4, 0, 0);
    do_access(1, 8'h55, 2, 0, 0);

    // Misses with no catch-all
    c_rd[7] = 0; c_wr[7] = 0;
    apply_cfg();
    do_access(1, 8'h80, 2, 0, 0);
    do_access(0, 8'h81, 2, 0, 0);
`ifdef IOPORT_DECODE_ERR_EN
    @(negedge clock);
    err_clr = 1'b1;
    @(negedge clock);
    err_clr = 1'b0;
    m_err = 0;
    check("err_clr_pulse", miss_err, 0);
`endif
    do_access(1, 8'h90, 2, 1, 0);

    // Randomized configurations and accesses
    for (int it = 0; it < 90; it++) begin
      if (it % 10 == 0) begin
        for (int c = 0; c < NUM_CH; c++) begin
          int pick;
          pick = $urandom_range(0, 4);
          c_base[c] = 8'($urandom);
          c_mask[c] = (pick == 0) ? 8'hFF : (pick == 1) ? 8'hF0 : (pick == 2) ? 8'hFE :
                      (pick == 3) ? 8'h00 : 8'($urandom);
          c_rd[c] = 1'($urandom);
          c_wr[c] = 1'($urandom);
          c_wt[c] = $urandom_range(0, 7);
        end
        apply_cfg();
      end
      begin
        logic [7:0] a;
        bit rd, clr;
        if ($urandom_range(0, 1) == 1)
          a = c_base[$urandom_range(0, NUM_CH - 1)] ^ 8'($urandom_range(0, 3));
        else
          a = 8'($urandom);
        rd  = 1'($urandom);
`ifdef IOPORT_DECODE_ERR_EN
        clr = ($urandom_range(0, 7) == 0);
`else
        clr = 0;
`endif
        do_access(rd, a, $urandom_range(1, 10), clr, 1);
      end
    end

    repeat (4) @(negedge clock);
    check("sb_remaining", sbq.size(), 0);
    check("strobe_count", n_seen, n_pushed);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/io_port_decoder_ws.md
Name: io_port_decoder_ws

Overview:
- Parametrised, registered successor to the fixed I/O port select logic.
- Decodes an 8-bit (parametrisable) I/O address against NUM_CH programmable base/mask windows, each with its own direction enables.
- Generates a held chip select and a single-cycle read/write strobe per access.
- Per-channel wait-state counter drives a CPU ready line; sits between the bus interface and the peripheral registers (console, LEDs, misc control, IOBYTE, RAM A16 latch, etc.).

Parameters:
- NUM_CH, 8: number of decode channels (1..16).
- ADDR_W, 8: I/O address width.
- WS_W, 3: wait-state count width; max wait = 2^WS_W-1 cycles.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- address  in  ADDR_W  I/O port address, stable while ioread/iowrite high.
- ioread  in  1  I/O read cycle active (level).
- iowrite  in  1  I/O write cycle active (level).
- ch_base  in  NUM_CH*ADDR_W  per-channel base address; channel n at [n*ADDR_W +: ADDR_W].
- ch_mask  in  NUM_CH*ADDR_W  per-channel compare mask; 1 = bit compared, 0 = don't care.
- ch_rd_en  in  NUM_CH  channel responds to reads.
- ch_wr_en  in  NUM_CH  channel responds to writes.
- ch_wait  in  NUM_CH*WS_W  wait states per channel.
- cs  out  NUM_CH  one-hot registered chip select, active high, held for the whole access.
- rd_stb  out  1  one-cycle read strobe.
- wr_stb  out  1  one-cycle write strobe.
- hit_idx  out  $clog2(NUM_CH)  index of the selected channel, valid while cs != 0.
- ready  out  1  registered; low while the access is in wait states.

Behaviour:
- Reset (sync, active-high): state IDLE; cs=0, rd_stb=0, wr_stb=0, hit_idx=0, ready=1, counter=0. Applies mid-access: everything aborts and no strobe is issued.
- Access request:
  - req = ioread XOR iowrite.
  - ioread&&iowrite together is illegal and treated as no request.
  - req_q is the registered req.
  - Access start = req && !req_q, sampled in IDLE only.
- Channel match n: ((address ^ base_n) & mask_n) == 0 && (ioread ? rd_en_n : wr_en_n).
- Priority: lowest matching index wins.
- Mask of all zeros matches every address (catch-all channel).
- States:
  - IDLE: on start with a hit:
    - latch idx and direction; cs <= onehot(idx); ready <= 0.
    - If ch_wait[idx] > 0: cnt <= ch_wait[idx], go to WAIT.
    - Else go to STROBE.
    - Start with no hit: stay IDLE, cs=0, ready=1, no strobe.
  - WAIT: cnt decrements each cycle; at cnt==1 go to STROBE. If req drops: go IDLE, cs <= 0, ready <= 1, no strobe.
  - STROBE: exactly one cycle; rd_stb or wr_stb = 1 per the latched direction; ready <= 1; go to HOLD.
  - HOLD: cs held, ready=1, strobes 0. When req==0: cs <= 0, go IDLE.
- Latency with wait=0:
  - Start sampled at edge E0.
  - cs high after E0.
  - Strobe high after E1 for one cycle.
  - ready high again after E1, cs held until req falls.
- Latency with wait=N: the strobe is delayed N extra cycles; ready is low for N+1 cycles.
- Config inputs are sampled only at start; changes mid-access are ignored.
- An address change mid-access is ignored (the latched idx is held).
- Back-to-back accesses need req to be low for at least one sampled cycle; a level held high never re-triggers.

Optional Feature:
- Macro: IOPORT_DECODE_ERR_EN.
- With the macro defined, add these outputs:
  - miss_err (1): sticky; set when an access start has no hit; cleared by reset or by err_clr (input, 1, pulse).
  - miss_addr (ADDR_W): address of the first miss since the last clear.
  - miss_wr (1): direction of that miss.
  - A miss and err_clr in the same cycle: the set wins.
- Without the macro: these ports and registers do not exist; misses are silent.

Decomposition:
- Shared package ioport_pkg holds:
  - State encoding enum: IDLE, WAIT, STROBE, HOLD.
  - Default widths (ADDR_W=8, WS_W=3).
  - Localparam channel-slot numbering used by the SBC top level: CON=0, FBAR=1, MISC=2, IOBYTE=3, RAMA16=4, PORTFF=5.
- One sub-module: ioport_match. Combinational; address plus flattened base/mask/enables in, lowest-index hit and hit flag out. The FSM/counter stays in the parent.

Test Plan:
- Reset while in WAIT (ch_wait=3, cycle 2): cs=0, ready=1, no strobe after reset; the next access starts cleanly.
- ch0 base 0x00 mask 0xFE rd-only; IN 0x01, wait 0: cs=0x01 after E0, rd_stb one cycle after E1, ready never low more than 1 cycle. OUT 0x01: no cs (direction gated).
- ch1 base 0x06 mask 0xFF rd+wr, ch_wait=2; OUT 0x06: ready low 3 cycles, wr_stb exactly 1 cycle, cs=0x02 held until iowrite falls.
- ch3 (0x36 exact) and ch7 (mask 0x00 catch-all) both enabled; IN 0x36: hit_idx=3; IN 0x55: hit_idx=7.
- ioread and iowrite high together on 0x06: no cs, no strobe, ready=1. Abort in WAIT (iowrite drops with cnt=2): cs clears next cycle, wr_stb never pulses.
- IOPORT_DECODE_ERR_EN, no catch-all:
  - IN 0x80 then OUT 0x81: miss_err=1, miss_addr=0x80, miss_wr=0.
  - err_clr pulse: clears miss_err.
  - err_clr coincident with a new miss: miss_err stays 1.
